// File: rtl/deser_arb_pkg.sv
// rtl/deser_arb_pkg.sv - shared types and helpers for the deserializer lane arbiter
//
// Contents:
//   arb_state_e : arbiter FSM states (IDLE, SHIFT, WAIT_VALID)
//   lane_idx_w  : width of an encoded lane index, never less than 1
package deser_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT      = 2'd1,
        WAIT_VALID = 2'd2
    } arb_state_e;

    function automatic int lane_idx_w(input int num_lanes);
        return (num_lanes > 1) ? $clog2(num_lanes) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin lane picker
//
// Ports:
//   req     in  NUM_LANES  request vector
//   pointer in  LW         lane with highest priority this cycle
//   enable  in  1          when low, no grant is produced
//   gnt     out NUM_LANES  one-hot grant (all zero when nothing wins)
//   idx     out LW         encoded index of the granted lane
// The pointer register lives in the parent; this block only searches.
module rr_arbiter
    import deser_arb_pkg::*;
#(
    parameter  int NUM_LANES = 4,
    localparam int LW        = lane_idx_w(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LW-1:0]        pointer,
    input  logic                 enable,
    output logic [NUM_LANES-1:0] gnt,
    output logic [LW-1:0]        idx
);

    // Walk lanes starting at the pointer, wrapping; the first requester wins.
    always_comb begin
        logic found;
        int   cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = (int'(pointer) + i) % NUM_LANES;
            if (enable && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = LW'(cand);
            end
        end
    end

endmodule

// File: rtl/deser_lane_arbiter.sv
// rtl/deser_lane_arbiter.sv - shares one deserializer between serial lanes, round-robin per word
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   lane_req            per-lane request for one word
//   lane_serial         per-lane serial bit
//   lane_bit_en         per-lane bit strobe
//   lane_gnt            one-hot grant, held for the whole word
//   deser_serial_in     to deserializer serial_in
//   deser_enable        to deserializer enable
//   deser_start         to deserializer start (first bit of a word)
//   deser_parallel_in   from deserializer parallel_out
//   deser_valid         from deserializer valid
//   word_data/word_lane captured word and its source lane
//   word_valid          output word held until word_ready
//   word_ready          downstream accept
//   timeout_err         one-cycle abort pulse for a stalled lane
//
// Build option: define DESER_ARB_TIMEOUT_EN to abort a word after
// TIMEOUT_CYCLES consecutive idle bit slots; otherwise timeout_err is 0
// and a stalled lane keeps the grant.
module deser_lane_arbiter
    import deser_arb_pkg::*;
#(
    parameter  int NUM_LANES      = 4,
    parameter  int DATA_WIDTH     = 8,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int LW             = lane_idx_w(NUM_LANES),
    localparam int CW             = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_LANES-1:0]  lane_req,
    input  logic [NUM_LANES-1:0]  lane_serial,
    input  logic [NUM_LANES-1:0]  lane_bit_en,
    output logic [NUM_LANES-1:0]  lane_gnt,
    output logic                  deser_serial_in,
    output logic                  deser_enable,
    output logic                  deser_start,
    input  logic [DATA_WIDTH-1:0] deser_parallel_in,
    input  logic                  deser_valid,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic [LW-1:0]         word_lane,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  timeout_err
);

    arb_state_e            state_q, state_d;
    logic [NUM_LANES-1:0]  gnt_q, gnt_d;
    logic [LW-1:0]         gidx_q, gidx_d;
    logic [LW-1:0]         ptr_q, ptr_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] word_data_q, word_data_d;
    logic [LW-1:0]         word_lane_q, word_lane_d;
    logic                  word_valid_q, word_valid_d;

`ifdef DESER_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]         idle_cnt_q, idle_cnt_d;
    logic                  timeout_q, timeout_d;
`endif

    logic                  slot_free;
    logic                  arb_en;
    logic [NUM_LANES-1:0]  arb_gnt;
    logic [LW-1:0]         arb_idx;
    logic                  cur_bit_en;
    logic                  cur_serial;
    logic                  in_shift;
    logic [LW-1:0]         next_ptr;

    // Slot is free when empty or being drained this cycle; a new word can
    // therefore never land on top of one that is still held.
    assign slot_free = !word_valid_q || word_ready;
    assign arb_en    = (state_q == IDLE) && slot_free;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES)
    ) u_rr (
        .req     (lane_req),
        .pointer (ptr_q),
        .enable  (arb_en),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    // Serial path is a plain mux from the registered grant so bits reach
    // the deserializer in the same cycle the lane presents them.
    assign cur_bit_en      = lane_bit_en[gidx_q];
    assign cur_serial      = lane_serial[gidx_q];
    assign in_shift        = (state_q == SHIFT);
    assign deser_enable    = in_shift && cur_bit_en;
    assign deser_serial_in = in_shift && cur_serial;
    assign deser_start     = deser_enable && (bit_cnt_q == '0);

    assign next_ptr = (gidx_q == LW'(NUM_LANES - 1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gidx_d       = gidx_q;
        ptr_d        = ptr_q;
        bit_cnt_d    = bit_cnt_q;
        word_data_d  = word_data_q;
        word_lane_d  = word_lane_q;
        word_valid_d = word_valid_q;
`ifdef DESER_ARB_TIMEOUT_EN
        idle_cnt_d   = idle_cnt_q;
        timeout_d    = 1'b0;
`endif

        if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (arb_gnt != '0) begin
                    gnt_d     = arb_gnt;
                    gidx_d    = arb_idx;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
`ifdef DESER_ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end

            SHIFT: begin
                if (cur_bit_en) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef DESER_ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    // Last bit accepted: release the lane on this same edge.
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                        gnt_d   = '0;
                        state_d = WAIT_VALID;
                    end
                end
`ifdef DESER_ARB_TIMEOUT_EN
                else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the word and move priority past the stalled lane.
                    timeout_d = 1'b1;
                    gnt_d     = '0;
                    ptr_d     = next_ptr;
                    state_d   = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
`endif
            end

            WAIT_VALID: begin
                if (deser_valid) begin
                    word_data_d  = deser_parallel_in;
                    word_lane_d  = gidx_q;
                    word_valid_d = 1'b1;
                    ptr_d        = next_ptr;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            gidx_q       <= '0;
            ptr_q        <= '0;
            bit_cnt_q    <= '0;
            word_data_q  <= '0;
            word_lane_q  <= '0;
            word_valid_q <= 1'b0;
`ifdef DESER_ARB_TIMEOUT_EN
            idle_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gidx_q       <= gidx_d;
            ptr_q        <= ptr_d;
            bit_cnt_q    <= bit_cnt_d;
            word_data_q  <= word_data_d;
            word_lane_q  <= word_lane_d;
            word_valid_q <= word_valid_d;
`ifdef DESER_ARB_TIMEOUT_EN
            idle_cnt_q   <= idle_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign lane_gnt   = gnt_q;
    assign word_data  = word_data_q;
    assign word_lane  = word_lane_q;
    assign word_valid = word_valid_q;

`ifdef DESER_ARB_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/deser_lane_arbiter.md
Name: deser_lane_arbiter

Overview:
- Shares one `deserializer` instance between NUM_LANES serial requesters.
- Grants lanes round-robin, one word at a time, and drives the deserializer's serial_in/enable/start.
- Captures the parallel word on deserializer valid and presents it downstream, tagged with its lane, over a valid/ready handshake.
- Sits between the lane front-ends and the word-level packet logic.

Parameters:
- NUM_LANES, 4, number of serial requesters (>=2).
- DATA_WIDTH, 8, word width; must match the attached deserializer.
- TIMEOUT_CYCLES, 64, idle-bit limit in SHIFT; used only with the optional feature.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- lane_req  in  NUM_LANES  per-lane request to transfer one word.
- lane_serial  in  NUM_LANES  per-lane serial data bit.
- lane_bit_en  in  NUM_LANES  per-lane bit strobe; the bit is valid when high.
- lane_gnt  out  NUM_LANES  one-hot grant, high for the whole word.
- deser_serial_in  out  1  to deserializer serial_in.
- deser_enable  out  1  to deserializer enable.
- deser_start  out  1  to deserializer start.
- deser_parallel_in  in  DATA_WIDTH  from deserializer parallel_out.
- deser_valid  in  1  from deserializer valid.
- word_data  out  DATA_WIDTH  captured word.
- word_lane  out  $clog2(NUM_LANES)  source lane of word_data.
- word_valid  out  1  output word held.
- word_ready  in  1  downstream accept.
- timeout_err  out  1  one-cycle abort pulse; tied 0 without the optional feature.

Behaviour:
- Reset state: FSM=IDLE, lane_gnt=0, word_valid=0, word_data=0, word_lane=0, timeout_err=0, rr pointer=0, bit_cnt=0.
- Reset also forces deser_enable=0 and deser_start=0. Mid-word reset abandons the word; no output is produced.
- Round-robin arbitration:
  - Search starts at the rr pointer.
  - The winner is the first lane at or above the pointer with lane_req high, wrapping modulo NUM_LANES.
  - When a word is captured, the pointer becomes winner+1, wrapping.
- IDLE:
  - Arbitrates only if some lane_req is high AND the output slot is free (word_valid=0, or word_valid&&word_ready this cycle).
  - On a win, registers the grant and moves to SHIFT. lane_gnt goes high the cycle after the request is seen.
- SHIFT:
  - deser_serial_in = lane_serial[g]; deser_enable = lane_bit_en[g]. Combinational mux from the registered grant.
  - deser_start = 1 only on the first enabled bit (bit_cnt==0 && lane_bit_en[g]).
  - bit_cnt increments on each enabled bit.
  - When the DATA_WIDTH-th enabled bit is accepted, goes to WAIT_VALID; lane_gnt drops the same edge.
  - Gaps between bits (lane_bit_en low) are legal and stall the count.
- WAIT_VALID:
  - deser_enable=0 and deser_start=0.
  - On deser_valid: word_data<=deser_parallel_in, word_lane<=g, word_valid<=1, rr pointer update, then IDLE.
  - The deserializer asserts valid exactly 1 cycle after the last bit, so WAIT_VALID lasts 1 cycle.
  - deser_valid outside WAIT_VALID is ignored.
- Latency:
  - Request to grant: 1 cycle.
  - Last bit to word_valid: 2 cycles (deserializer register plus capture register).
  - Back-to-back: the next grant can issue in the cycle after capture.
- Output handshake:
  - word_valid holds, with word_data/word_lane stable, until word_valid&&word_ready.
  - A simultaneous accept and new capture is impossible, because IDLE gates on a free slot.
- lane_req dropped mid-word: ignored; the word completes.
- Grant changes only in IDLE.
- A lone requester is re-granted after each word.
- Bit counter width is $clog2(DATA_WIDTH+1); it never wraps.

Optional Feature:
- DESER_ARB_TIMEOUT_EN defined:
  - An idle counter in SHIFT counts consecutive cycles with lane_bit_en[g]=0; it clears on each enabled bit.
  - Reaching TIMEOUT_CYCLES does all of the following: pulses timeout_err for 1 cycle, drops lane_gnt, advances the rr pointer past g, and returns to IDLE with no output word.
  - The deserializer is resynchronised by the next grant's start pulse.
- Undefined:
  - No counter; a stalled lane holds the grant indefinitely.
  - timeout_err is tied 0.

Decomposition:
- Package deser_arb_pkg holds:
  - typedef arb_state_e {IDLE, SHIFT, WAIT_VALID};
  - function lane_idx_w(NUM_LANES) returning $clog2(NUM_LANES).
- One natural sub-module, rr_arbiter:
  - Parameter NUM_LANES; inputs req, pointer, enable.
  - Outputs one-hot gnt and encoded index, combinational.
  - Pointer register stays in the parent.

Test Plan:
- Single lane 1 req, bits 1,0,1,0,0,1,0,1 with lane_bit_en continuous -> deser_start on bit 1 only; word_data=8'hA5, word_lane=1, word_valid 2 cycles after the last bit.
- Lanes 0–3 all req continuously, each sending its own lane index as a word -> grants in order 0,1,2,3,0; words 0x00,0x01,0x02,0x03 arrive in that order.
- Backpressure: word_ready=0 for 20 cycles after the first word, lane 2 requesting -> no grant while word_valid=1; grant 1 cycle after the accept edge; word_data stable throughout.
- Bit gaps: lane_bit_en pattern 1,0,0,1,... over 8 bits -> correct word, bit_cnt stalls in gaps, exactly one deser_start.
- Reset asserted on bit 5 of a word -> all outputs 0 immediately (async); after release, a new request yields a clean full word.
- With DESER_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: lane 0 stops after 3 bits, lane 1 requesting -> timeout_err pulses 8 idle cycles later, no word from lane 0; lane 1 granted next and its word is correct.
